// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: state codes, drain counter
// width and PC type.
package fetch_sequencer_pkg;

    localparam int ST_W        = 2;
    localparam int DRAIN_CNT_W = 4;
    localparam int PC_W        = 32;

    typedef logic [ST_W-1:0]        fetch_seq_state_t;
    typedef logic [DRAIN_CNT_W-1:0] drain_cnt_t;
    typedef logic [PC_W-1:0]        pc_t;

    localparam fetch_seq_state_t ST_RUN      = 2'd0;
    localparam fetch_seq_state_t ST_REDIRECT = 2'd1;
    localparam fetch_seq_state_t ST_DRAIN    = 2'd2;

    localparam pc_t PC_RESET = '0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Request/control bundle between execute/commit logic and the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  decodeStallReq;
    logic                  exRedirectValid;
    logic [ADDR_WIDTH-1:0] exRedirectPc;
    logic                  trapValid;
    logic [ADDR_WIDTH-1:0] trapPc;
    logic                  fenceReq;
    logic [ADDR_WIDTH-1:0] fencePc;

    logic                  fetchStall;
    logic                  fetchFlush;
    logic                  decodeFlush;
    logic                  irregPcValid;
    logic [ADDR_WIDTH-1:0] irregPc;
    logic                  fenceDone;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  mispredictCount;

    // requester side: execute/commit logic and fetch stage
    modport master (
        output decodeStallReq, exRedirectValid, exRedirectPc,
               trapValid, trapPc, fenceReq, fencePc,
        input  fetchStall, fetchFlush, decodeFlush, irregPcValid,
               irregPc, fenceDone, busy, mispredictCount
    );

    modport slave (
        input  decodeStallReq, exRedirectValid, exRedirectPc,
               trapValid, trapPc, fenceReq, fencePc,
        output fetchStall, fetchFlush, decodeFlush, irregPcValid,
               irregPc, fenceDone, busy, mispredictCount
    );
endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter; holds at all-ones. Reusable for performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (inc && (count_q != '1))
            count_q <= count_q + WIDTH'(1);
    end

    assign count = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: prioritizes trap/mispredict/fence/decode-stall into
// fetch control, with a registered redirect and a bounded fence.i drain.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input logic              clk,
    input logic              rst,
    fetch_sequencer_if.slave bus
);
    fetch_seq_state_t      state_q, state_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    drain_cnt_t            cnt_q, cnt_d;

    logic stall, fflush, dflush, done, mp_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        fflush  = 1'b0;
        dflush  = 1'b0;
        done    = 1'b0;
        mp_inc  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.trapValid) begin
                    fflush  = 1'b1;
                    dflush  = 1'b1;
                    tgt_d   = bus.trapPc;
                    state_d = ST_REDIRECT;
                end else if (bus.exRedirectValid) begin
                    fflush  = 1'b1;
                    dflush  = 1'b1;
                    mp_inc  = 1'b1;
                    tgt_d   = bus.exRedirectPc;
                    state_d = ST_REDIRECT;
                end else if (bus.fenceReq) begin
                    stall   = 1'b1;
                    fflush  = 1'b1;
                    dflush  = 1'b1;
                    tgt_d   = bus.fencePc;
                    cnt_d   = drain_cnt_t'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end else if (bus.decodeStallReq) begin
                    stall   = 1'b1;
                end
            end
            ST_REDIRECT: begin
                // IMem output this cycle still belongs to the old PC
                fflush  = 1'b1;
                state_d = ST_RUN;
                if (bus.trapValid) begin
                    tgt_d   = bus.trapPc;
                    state_d = ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                stall  = 1'b1;
                fflush = 1'b1;
                if (bus.trapValid) begin
                    tgt_d   = bus.trapPc;
                    state_d = ST_REDIRECT;
                end else if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d   = cnt_q - drain_cnt_t'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mp_inc),
        .count (bus.mispredictCount)
    );

    // PC outputs depend on registered state only
    assign bus.irregPcValid = (state_q == ST_REDIRECT);
    assign bus.irregPc      = (state_q == ST_REDIRECT) ? tgt_q : '0;
    assign bus.fetchStall   = stall;
    assign bus.fetchFlush   = fflush;
    assign bus.decodeFlush  = dflush;
    assign bus.fenceDone    = done;
    assign bus.busy         = (state_q != ST_RUN);
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Central sequencer for the fetch stage. It merges redirect, trap, fence and decode-stall requests into one prioritized control set for the fetch stage: stall, flush, irregular-PC valid and irregular-PC value. It sits between the execute/commit logic and the fetch stage. A small FSM provides registered redirects and a bounded pipeline drain for fence.i. It also keeps a saturating mispredict counter.

Parameters:
ADDR_WIDTH, 32, PC width; matches the PC type.
DRAIN_CYCLES, 3, bubble cycles inserted for fence.i before refetch; legal range 1..15.
CNT_WIDTH, 32, width of the mispredict counter.

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
decodeStallReq  input  1  decode hazard; hold fetch
exRedirectValid  input  1  execute detected branch mispredict
exRedirectPc  input  ADDR_WIDTH  correct target for the mispredict
trapValid  input  1  trap/exception redirect request
trapPc  input  ADDR_WIDTH  trap vector
fenceReq  input  1  fence.i reached execute (single-cycle pulse)
fencePc  input  ADDR_WIDTH  PC of fence.i + 4
fetchStall  output  1  fetch-stage stall
fetchFlush  output  1  zero the fetch to decode pipe register
decodeFlush  output  1  kill the instruction in decode
irregPcValid  output  1  fetch must load irregPc as its next PC
irregPc  output  ADDR_WIDTH  redirect target (registered)
fenceDone  output  1  one-cycle pulse when fence refetch issues
busy  output  1  state != RUN
mispredictCount  output  CNT_WIDTH  accepted mispredicts, saturating

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at a posedge):
  - state = RUN; target register = 0; drain counter = 0; mispredictCount = 0.
  - Every output is 0 in the cycle after reset.
  - Reset asserted mid-drain or mid-redirect aborts the operation. No fenceDone is produced.
- States: RUN, REDIRECT, DRAIN.
- RUN, combinational priority (highest first):
  1. trapValid: fetchFlush=1, decodeFlush=1; latch trapPc; next state REDIRECT.
  2. exRedirectValid: same outputs; latch exRedirectPc; mispredictCount += 1, saturating at all-ones; next state REDIRECT.
  3. fenceReq: fetchStall=1, fetchFlush=1, decodeFlush=1; latch fencePc; load counter with DRAIN_CYCLES-1; next state DRAIN.
  4. decodeStallReq: fetchStall=1, fetchFlush=0; stay in RUN.
  5. Otherwise all outputs 0.
- REDIRECT (exactly 1 cycle):
  - irregPcValid=1, irregPc = latched target, fetchFlush=1 (the synchronous IMem output still belongs to the old PC), fetchStall=0.
  - decodeStallReq is ignored.
  - Next state is RUN. Fetch delivers the target instruction in the following cycle.
  - If trapValid=1 in this cycle: re-latch trapPc and stay in REDIRECT one more cycle.
  - exRedirectValid and fenceReq in REDIRECT are ignored (they come from a squashed path) and are not counted.
- DRAIN:
  - fetchStall=1, fetchFlush=1, decodeFlush=0.
  - The counter decrements each cycle. When counter==0, next state is REDIRECT to the latched fencePc and fenceDone=1 for that one transition cycle (the last DRAIN cycle).
  - trapValid during DRAIN overrides: latch trapPc, go to REDIRECT, no fenceDone.
  - exRedirectValid, fenceReq and decodeStallReq are ignored in DRAIN.
- Total fence latency: fenceReq at cycle T gives irregPcValid at T+DRAIN_CYCLES+1.
- Outputs decodeFlush and fetchFlush are combinational from state plus inputs. irregPc and irregPcValid are functions of registered state only (no input-to-PC path).
- mispredictCount holds at all-ones once saturated. Trap-caused redirects do not count.

Decomposition:
- Shared package FetchCtrlTypes:
  - state enum FetchSeqState {RUN, REDIRECT, DRAIN}.
  - DRAIN counter width constant (4 bits).
  - PC type and RESET constant reused from BasicTypes.
- One sub-module: sat_counter (parameter WIDTH; ports clk, rst, inc, count). It holds at max and is reusable for other performance counters.

Test Plan:
1. Reset: hold rst=1 two cycles with all requests high, then release with requests low. Required: all outputs 0, state RUN, mispredictCount=0.
2. Mispredict: exRedirectValid=1, exRedirectPc=0x0000_0100 at cycle T. Required: T shows fetchFlush=decodeFlush=1. T+1 shows irregPcValid=1, irregPc=0x100, fetchFlush=1. T+2 shows all outputs 0, busy=0, mispredictCount=1.
3. Priority: trapValid (trapPc=0x0000_0040) together with exRedirectValid (0x200) and decodeStallReq. Required: irregPc=0x40 at T+1; mispredictCount unchanged.
4. Fence with DRAIN_CYCLES=3: fenceReq with fencePc=0x0000_0088 at T. Required: fetchStall=1 for T..T+3; fenceDone=1 only at T+3; irregPcValid=1 with irregPc=0x88 at T+4.
5. Trap mid-drain: fenceReq at T, trapValid (0x40) at T+2. Required: irregPc=0x40 at T+3; fenceDone never asserted.
6. Decode stall and saturation:
   - decodeStallReq alone for 5 cycles. Required: fetchStall=1, fetchFlush=0 each cycle.
   - With CNT_WIDTH=2, issue 5 mispredicts. Required: mispredictCount sticks at 3.
